program_memory_slave: RTL and testbench
=======================================

// Module: program_memory_slave
//
// PURPOSE
//  Parametrised Avalon-MM slave memory with programmable wait states and a fixed
//  read-side left shift. Sits behind the host bridge as a program/data store.
//  Generalises the single-width, free-running-counter stall scheme into a
//  per-transaction wait-state FSM with configurable depth, width and latency.
//
// PARAMETERS
//  DATA_WIDTH   32  width of s0_writedata / s0_readdata
//  ADDR_WIDTH   7   word-address bits used; depth = 2**ADDR_WIDTH words
//  WAIT_CYCLES  2   cycles s0_waitrequest is held high per transaction (0..255)
//  READ_SHIFT   1   left shift applied to read data, 0..DATA_WIDTH-1, zero-fill
//
// PORTS
//  clk             in   1           clock, all logic on rising edge
//  reset           in   1           asynchronous, active-high reset
//  s0_address      in   32          word address
//  s0_read         in   1           read request
//  s0_write        in   1           write request
//  s0_readdata     out  DATA_WIDTH  read data, valid only in ACK cycle of a read
//  s0_writedata    in   DATA_WIDTH  write data
//  s0_waitrequest  out  1           stall; master holds request/address/data while high
//  s0_byteenable   in   DATA_WIDTH/8  only present with PROGRAM_MEM_BYTEENABLE_EN
//
// BEHAVIOUR
//  - idx = s0_address[ADDR_WIDTH-1:0]; in_range = s0_address[31:ADDR_WIDTH]==0.
//  - Memory contents zero at configuration; reset does NOT clear the array.
//  - FSM states IDLE, WAIT, ACK; down-counter cnt, 8 bits. Reset: state=IDLE, cnt=0.
//  - req = s0_read | s0_write. s0_waitrequest = req && state!=ACK (WAIT_CYCLES>0);
//    constant 0 when WAIT_CYCLES==0. Purely combinational from state and req.
//  - IDLE: req -> (WAIT_CYCLES==1 ? ACK : WAIT, cnt=WAIT_CYCLES-1); else stay.
//  - WAIT: cnt<=cnt-1; cnt==1 -> ACK. req dropped (protocol violation) -> IDLE, no access.
//  - ACK: waitrequest low one cycle; access performed; -> IDLE unconditionally.
//    Back-to-back requests therefore see WAIT_CYCLES stall cycles each, never 0.
//  - WAIT_CYCLES==0: FSM bypassed; every cycle with req is an ACK cycle.
//  - Write: mem[idx] <= s0_writedata on the edge ending the ACK cycle, only if in_range.
//  - Read: s0_readdata = (mem[idx] << READ_SHIFT) truncated to DATA_WIDTH in the
//    ACK cycle if in_range; 0 if out of range, in non-ACK cycles and during reset.
//  - s0_read && s0_write together: treated as write; s0_readdata returns the
//    pre-write contents of mem[idx].
//  - Reset asserted mid-transaction: FSM to IDLE immediately, pending access
//    discarded (no write committed); after release a held request restarts
//    with the full WAIT_CYCLES stall.
//
// CONFIGURATION
//  PROGRAM_MEM_BYTEENABLE_EN defined: s0_byteenable port exists; on a write only
//   bytes with byteenable[i]=1 are updated; reads ignore byteenable.
//   DATA_WIDTH must be a multiple of 8.
//  Undefined: no s0_byteenable port; every write updates the full word.
//
// TESTING
//  1 W=2: write 0x0000_0005 to addr 3 -> waitrequest high 2 cycles, low 1;
//    read addr 3 -> readdata 0x0000_000A in ACK cycle, 0 otherwise.
//  2 W=0: back-to-back writes addr 0..127 with data=addr, reads -> waitrequest
//    never high, readdata = addr<<1 same cycle; addr 128 write leaves addr 0 = 0.
//  3 Read of 0x8000_0001 (out of range) -> readdata 0 after stall, mem unchanged.
//  4 Reset pulsed in WAIT of write 0xDEAD_BEEF to addr 7 -> addr 7 unchanged;
//    held request after release stalls full WAIT_CYCLES then commits.
//  5 read+write together, addr 9 holding 0x11 -> readdata 0x22, addr 9 = new data.
//  6 BYTEENABLE_EN: addr 2 = 0xFFFF_FFFF, write 0x1234_5678 be=4'b0101
//    -> readback (pre-shift) 0xFF34_FF78.

Source files
------------

// File: rtl/program_memory_slave.sv
// Avalon-MM slave memory: per-transaction wait-state FSM, left-shifted read data.
// Define PROGRAM_MEM_BYTEENABLE_EN to add s0_byteenable and byte-lane writes.
module program_memory_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_CYCLES = 2,
  parameter int READ_SHIFT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  output logic [DATA_WIDTH-1:0] s0_readdata,
  input  logic [DATA_WIDTH-1:0] s0_writedata,
  output logic                  s0_waitrequest
`ifdef PROGRAM_MEM_BYTEENABLE_EN
  ,
  input  logic [DATA_WIDTH/8-1:0] s0_byteenable
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [7:0] CNT_INIT = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    in_range;
  logic                    req;
  logic                    ack;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign idx      = s0_address[ADDR_WIDTH-1:0];
  assign in_range = (s0_address[31:ADDR_WIDTH] == '0);
  assign req      = s0_read | s0_write;

  // Every transaction pays the full stall; ACK always returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt   <= CNT_INIT;
          state <= (WAIT_CYCLES == 1) ? ACK : WAIT;
        end
        WAIT: if (!req) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign ack            = req & ~reset;
      assign s0_waitrequest = 1'b0;
    end else begin : g_wait
      assign ack            = req & ~reset & (state == ACK);
      assign s0_waitrequest = req & (state != ACK);
    end
  endgenerate

  // A simultaneous read+write is a write; the read port still sees old contents.
  assign wr_en   = ack & s0_write & in_range;
  assign rd_word = mem[idx];

  always_comb begin
    s0_readdata = '0;
    if (ack && s0_read && in_range) s0_readdata = rd_word << READ_SHIFT;
  end

  // Array is never reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
`ifdef PROGRAM_MEM_BYTEENABLE_EN
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (s0_byteenable[b]) mem[idx][b*8 +: 8] <= s0_writedata[b*8 +: 8];
`else
      mem[idx] <= s0_writedata;
`endif
    end
  end

endmodule

// File: tb/tb_program_memory_slave.sv
// Directed bench: one instance with 2 wait states, one with none, both shifting reads by 1.
module tb_program_memory_slave;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rd, a_wr, a_wait;
  logic [3:0]  a_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_rd, b_wr, b_wait;
  logic [3:0]  b_be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  program_memory_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_CYCLES(2), .READ_SHIFT(1)) dut (
    .clk(clk), .reset(reset), .s0_address(a_addr), .s0_read(a_rd), .s0_write(a_wr),
    .s0_readdata(a_rdata), .s0_writedata(a_wdata), .s0_waitrequest(a_wait)
`ifdef PROGRAM_MEM_BYTEENABLE_EN
    , .s0_byteenable(a_be)
`endif
  );

  program_memory_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WAIT_CYCLES(0), .READ_SHIFT(1)) dut0 (
    .clk(clk), .reset(reset), .s0_address(b_addr), .s0_read(b_rd), .s0_write(b_wr),
    .s0_readdata(b_rdata), .s0_writedata(b_wdata), .s0_waitrequest(b_wait)
`ifdef PROGRAM_MEM_BYTEENABLE_EN
    , .s0_byteenable(b_be)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic a_set(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] d, input logic [3:0] be);
    a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = d; a_be = be;
  endtask

  task automatic a_idle();
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  // Two stall cycles then one ACK cycle; readdata must be 0 while stalled.
  task automatic a_run(input string tag, input logic [31:0] exp_rd, input logic chk_ack_rd);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, "_wait"}, 32'(a_wait), 32'(k < 2));
      if (k < 2)         chk({tag, "_rd_stall"}, a_rdata, 32'h0);
      else if (chk_ack_rd) chk({tag, "_rd_ack"}, a_rdata, exp_rd);
      @(posedge clk); #1;
    end
    a_idle();
  endtask

  task automatic a_write(input string tag, input logic [31:0] addr, input logic [31:0] d);
    a_set(1'b0, 1'b1, addr, d, 4'hF);
    a_run(tag, 32'h0, 1'b0);
  endtask

  task automatic a_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a_set(1'b1, 1'b0, addr, 32'h0, 4'hF);
    a_run(tag, exp, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    a_set(1'b1, 1'b0, 32'd3, 32'h0, 4'hF);
    b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'd0; b_wdata = 32'h0; b_be = 4'hF;

    // Reset: requests stall (FSM not in ACK) and readdata stays 0.
    @(negedge clk);
    chk("rst_wait_req", 32'(a_wait), 32'h1);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_w0_wait", 32'(b_wait), 32'h0);
    chk("rst_w0_rdata", b_rdata, 32'h0);
    a_idle(); b_rd = 1'b0;
    @(negedge clk);
    chk("rst_wait_idle", 32'(a_wait), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic write/read with 2 wait states, shift by 1.
    a_write("t1_wr", 32'd3, 32'h0000_0005);
    a_read ("t1_rd", 32'd3, 32'h0000_000A);
    // Shift truncates the MSB.
    a_write("shl_wr", 32'd5, 32'h8000_0001);
    a_read ("shl_rd", 32'd5, 32'h0000_0002);

    // Out of range: read returns 0, write is dropped.
    a_write("t3_pre", 32'd1, 32'h0000_0033);
    a_read ("t3_oor_rd", 32'h8000_0001, 32'h0);
    a_write("t3_oor_wr", 32'h8000_0003, 32'h0000_0099);
    a_read ("t3_chk1", 32'd1, 32'h0000_0066);
    a_read ("t3_chk3", 32'd3, 32'h0000_000A);

    // Reset in WAIT with the request dropped afterwards: no commit.
    a_write("t4_pre", 32'd7, 32'h0000_0001);
    a_set(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); chk("t4b_c0_wait", 32'(a_wait), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); chk("t4b_rst_wait", 32'(a_wait), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0; a_idle();
    a_read("t4b_rd", 32'd7, 32'h0000_0002);

    // Reset in WAIT with request held: full stall restarts, then commits.
    a_set(1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); chk("t4a_c0_wait", 32'(a_wait), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); chk("t4a_rst_wait", 32'(a_wait), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    a_run("t4a_restart", 32'h0, 1'b0);
    a_read("t4a_rd", 32'd7, 32'hBD5B_7DDE);

    // Read+write together: old data out, new data stored.
    a_write("t5_pre", 32'd9, 32'h0000_0011);
    a_set(1'b1, 1'b1, 32'd9, 32'h0000_0055, 4'hF);
    a_run("t5_rw", 32'h0000_0022, 1'b1);
    a_read("t5_rd", 32'd9, 32'h0000_00AA);

    // Request dropped in WAIT: aborted, no write.
    a_write("pv_pre", 32'd10, 32'h0000_0004);
    a_set(1'b0, 1'b1, 32'd10, 32'h0000_0007, 4'hF);
    @(negedge clk); chk("pv_c0_wait", 32'(a_wait), 32'h1);
    @(posedge clk); #1;
    a_idle();
    @(negedge clk); chk("pv_drop_wait", 32'(a_wait), 32'h0);
    @(posedge clk); #1;
    a_read("pv_rd", 32'd10, 32'h0000_0008);

`ifdef PROGRAM_MEM_BYTEENABLE_EN
    a_write("t6_full", 32'd2, 32'hFFFF_FFFF);
    a_set(1'b0, 1'b1, 32'd2, 32'h1234_5678, 4'b0101);
    a_run("t6_be_wr", 32'h0, 1'b0);
    a_set(1'b1, 1'b0, 32'd2, 32'h0, 4'b0000);
    a_run("t6_rd", 32'hFE69_FEF0, 1'b1);
`endif

    // Zero wait states: back-to-back, never stalls.
    for (int a = 0; a < 128; a++) begin
      b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'(a); b_wdata = 32'(a);
      @(negedge clk);
      chk("t2_wr_wait", 32'(b_wait), 32'h0);
      @(posedge clk); #1;
    end
    for (int a = 0; a < 128; a++) begin
      b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'(a);
      @(negedge clk);
      chk("t2_rd_wait", 32'(b_wait), 32'h0);
      chk("t2_rd_data", b_rdata, 32'(a) << 1);
      @(posedge clk); #1;
    end
    b_rd = 1'b0; b_wr = 1'b1; b_addr = 32'd128; b_wdata = 32'h0000_00FF;
    @(posedge clk); #1;
    b_rd = 1'b1; b_wr = 1'b0; b_addr = 32'd0;
    @(negedge clk);
    chk("t2_addr0", b_rdata, 32'h0);
    b_addr = 32'd127;
    @(negedge clk);
    chk("t2_addr127", b_rdata, 32'h0000_00FE);
    b_rd = 1'b0;
    @(negedge clk);
    chk("t2_idle_rd", b_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
